gpio_walk_sequencer: RTL and testbench
======================================

GPIO_WALK_SEQUENCER -- requirements
Module: gpio_walk_sequencer

Interface
REQ-001 Parameter WIDTH, 34, number of sequenced user GPIO outputs (order {io[37:5], io[0]}, bit 0 = io[0]).
REQ-002 Parameter CNT_W, 16, width of the hold-period counter.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 wb_rst_i  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle request to begin a sequence; sampled only in IDLE.
REQ-007 abort  input  1  terminate any running sequence.
REQ-008 period  input  CNT_W  cycles each pattern is held; latched on accepted start.
REQ-009 iterations  input  4  number of walking-one passes; latched on accepted start.
REQ-010 drive_en  input  1  enables output drivers.
REQ-011 gpio_out  output  WIDTH  pattern driven to pads.
REQ-012 gpio_oeb  output  WIDTH  active-low output enables, all bits equal ~drive_en, registered (1-cycle latency).
REQ-013 busy  output  1  high from the cycle after an accepted start until the sequence ends.
REQ-014 done  output  1  single-cycle pulse on normal completion.

Function
REQ-015 FSM states IDLE, ZERO, WALK, FINISH; all outputs registered.
REQ-016 start in IDLE with iterations>0 accepted: next cycle state=ZERO, busy=1, gpio_out=0, pass counter=iterations, hold counter loaded.
REQ-017 Effective hold P = period, except period==0 treated as 1.
REQ-018 ZERO holds gpio_out=0 for P cycles; then WALK if passes remain, else FINISH.
REQ-019 WALK drives one-hot gpio_out starting at bit 0, each bit for P cycles, shifting left; after bit WIDTH-1 hold expires: pass counter decrements, state=ZERO.
REQ-020 Sequence shape for N passes: ZERO, WALK, ZERO, ..., WALK, ZERO; total busy cycles = (N+1)*P + N*WIDTH*P.
REQ-021 FINISH lasts exactly 1 cycle: done=1, busy=0, gpio_out=0; then IDLE.
REQ-022 start in IDLE with iterations==0: no busy, done pulses the next cycle, gpio_out stays 0.
REQ-023 start while not IDLE ignored; period/iterations changes after acceptance have no effect.
REQ-024 abort in any non-IDLE state: next cycle IDLE, gpio_out=0, busy=0, no done pulse.
REQ-025 abort and start in the same IDLE cycle: abort wins, start dropped.
REQ-026 gpio_out is never more than one-hot; no bit other than the walking bit is ever 1.
REQ-027 Hold counter counts down from P-1 to 0; advance on 0; no wrap beyond CNT_W.

Reset
REQ-028 wb_rst_i high: state=IDLE, gpio_out=0, gpio_oeb=all 1, busy=0, done=0, counters=0.
REQ-029 Reset asserted mid-sequence behaves as abort plus gpio_oeb forced to all 1; no done pulse.
REQ-030 First accepted start possible in the first cycle after reset deasserts.

Structure
REQ-031 Package gpio_seq_pkg holds the state enum, WIDTH default, and pass-counter width constant.
REQ-032 One sub-module gpio_seq_tick: loadable hold-period down-counter with expiry flag; FSM and shift register stay in top.

Verification
REQ-033 Reset, drive_en=1, start with period=2, iterations=1: gpio_out 0 for 2 cycles, then 34'h1..34'h2_0000_0000 each 2 cycles, then 0 for 2 cycles, done pulses once; busy high 72 cycles.
REQ-034 period=0, iterations=2: each pattern held 1 cycle; sequence 0, walk, 0, walk, 0; busy high 71 cycles; done once.
REQ-035 abort asserted while gpio_out=34'h100: next cycle gpio_out=0, busy=0; done never pulses; new start then accepted normally.
REQ-036 start re-pulsed mid-run and period changed to 5 mid-run: timing unchanged from original period=3 run.
REQ-037 iterations=0 start: done pulse next cycle, busy never 1; abort+start same cycle: no activity.
REQ-038 wb_rst_i asserted mid-WALK: next cycle gpio_out=0, gpio_oeb=all 1, busy=0; assertion checker: gpio_out always zero or one-hot.

Source files
------------

// File: rtl/gpio_seq_pkg.sv
// Shared types and constants for the GPIO walking-one sequencer.
// Holds the sequencer state encoding, default widths and pass-counter width.
package gpio_seq_pkg;

    localparam int DEF_WIDTH = 34;
    localparam int DEF_CNT_W = 16;
    localparam int PASS_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ZERO   = 2'd1,
        ST_WALK   = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_e;

endpackage

// File: rtl/gpio_seq_tick.sv
// Loadable hold-period down-counter; expired is high while the count is 0.
// Ports: wb_clk_i/wb_rst_i, clear, load+load_val, dec, expired.
module gpio_seq_tick #(
    parameter int CNT_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             clear,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            // Saturate at zero; the FSM reloads on expiry.
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/gpio_walk_sequencer.sv
// Drives a walking-one pattern across the user GPIOs for N passes.
// Ports: wb_clk_i/wb_rst_i, start/abort/period/iterations/drive_en in;
// gpio_out/gpio_oeb/busy/done out, all registered.
module gpio_walk_sequencer
    import gpio_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  period,
    input  logic [PASS_W-1:0] iterations,
    input  logic              drive_en,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oeb,
    output logic              busy,
    output logic              done
);

    seq_state_e        state;
    logic [PASS_W-1:0] pass_cnt;
    logic [CNT_W-1:0]  hold_m1;
    logic [CNT_W-1:0]  period_m1;
    logic              accept;
    logic              active;
    logic              expired;
    logic              tick_load;
    logic [CNT_W-1:0]  tick_val;

    // Period 0 behaves as 1, so the reload value is period-1 floored at 0.
    assign period_m1 = (period == '0) ? '0 : period - CNT_W'(1);

    assign accept = (state == ST_IDLE) && start && !abort;
    assign active = (state == ST_ZERO) || (state == ST_WALK);

    always_comb begin
        tick_load = 1'b0;
        tick_val  = hold_m1;
        if (accept && (iterations != '0)) begin
            tick_load = 1'b1;
            tick_val  = period_m1;
        end else if (active && !abort && expired) begin
            tick_load = 1'b1;
        end
    end

    gpio_seq_tick #(
        .CNT_W(CNT_W)
    ) u_tick (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .clear   (active && abort),
        .load    (tick_load),
        .dec     (active),
        .load_val(tick_val),
        .expired (expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            gpio_oeb <= '1;
        end else begin
            gpio_oeb <= {WIDTH{~drive_en}};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            pass_cnt <= '0;
            hold_m1  <= '0;
            gpio_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        hold_m1  <= period_m1;
                        pass_cnt <= iterations;
                        gpio_out <= '0;
                        if (iterations != '0) begin
                            state <= ST_ZERO;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_ZERO: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        gpio_out <= '0;
                    end else if (expired) begin
                        if (pass_cnt != '0) begin
                            state    <= ST_WALK;
                            gpio_out <= WIDTH'(1);
                        end else begin
                            state <= ST_FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_WALK: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        gpio_out <= '0;
                    end else if (expired) begin
                        if (gpio_out[WIDTH-1]) begin
                            state    <= ST_ZERO;
                            pass_cnt <= pass_cnt - PASS_W'(1);
                            gpio_out <= '0;
                        end else begin
                            gpio_out <= gpio_out << 1;
                        end
                    end
                end
                ST_FINISH: begin
                    state    <= ST_IDLE;
                    gpio_out <= '0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    gpio_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_walk_sequencer.sv
// Randomized self-checking bench for gpio_walk_sequencer.
// Expected waveforms come from a queue built from the sequence rules.
module tb_gpio_walk_sequencer;

    localparam int W  = 34;
    localparam int CW = 16;

    logic          wb_clk_i;
    logic          wb_rst_i;
    logic          start;
    logic          abort;
    logic [CW-1:0] period;
    logic [3:0]    iterations;
    logic          drive_en;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oeb;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    gpio_walk_sequencer #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .start     (start),
        .abort     (abort),
        .period    (period),
        .iterations(iterations),
        .drive_en  (drive_en),
        .gpio_out  (gpio_out),
        .gpio_oeb  (gpio_oeb),
        .busy      (busy),
        .done      (done)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    always @(negedge wb_clk_i) begin
        assert ($onehot0(gpio_out))
        else $error("gpio_out not zero/one-hot: %h", gpio_out);
    end

    task automatic run_seq(input int p, input int n, input bit perturb);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] one;
        int pe;
        int busy_seen;
        pe = (p == 0) ? 1 : p;
        one = 1;
        for (int k = 0; k < pe; k++) exp_q.push_back('0);
        for (int s = 0; s < n; s++) begin
            for (int b = 0; b < W; b++)
                for (int k = 0; k < pe; k++) exp_q.push_back(one << b);
            for (int k = 0; k < pe; k++) exp_q.push_back('0);
        end
        @(negedge wb_clk_i);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL idle_before_start busy=%b done=%b want 0 0",
                     busy, done);
        end
        period     = CW'(p);
        iterations = 4'(n);
        start      = 1'b1;
        wb_rst_i   = 1'b0;
        @(negedge wb_clk_i);
        start = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (busy === 1'b1) busy_seen++;
            tests++;
            if (gpio_out !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL seq p=%0d n=%0d cyc=%0d out=%h busy=%b done=%b want %h 1 0",
                         p, n, i, gpio_out, busy, done, exp_q[i]);
            end
            tests++;
            if (gpio_oeb !== {W{~drive_en}}) begin
                fails++;
                $display("FAIL oeb cyc=%0d got=%h want=%h",
                         i, gpio_oeb, {W{~drive_en}});
            end
            if (perturb && i == 10) begin
                start      = 1'b1;
                period     = 16'd5;
                iterations = 4'd7;
            end else if (perturb && i == 11) begin
                start = 1'b0;
            end
            @(negedge wb_clk_i);
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || gpio_out !== '0) begin
            fails++;
            $display("FAIL finish p=%0d n=%0d done=%b busy=%b out=%h want 1 0 0",
                     p, n, done, busy, gpio_out);
        end
        tests++;
        if (busy_seen != (n + 1) * pe + n * W * pe) begin
            fails++;
            $display("FAIL busy_len got=%0d want=%0d",
                     busy_seen, (n + 1) * pe + n * W * pe);
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        drive_en = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        tests++;
        if (gpio_out !== '0 || gpio_oeb !== '1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset out=%h oeb=%h busy=%b done=%b want 0 all1 0 0",
                     gpio_out, gpio_oeb, busy, done);
        end
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        tests++;
        if (gpio_oeb !== '0) begin
            fails++;
            $display("FAIL oeb_enable got=%h want=0", gpio_oeb);
        end
    endtask

    task automatic test_directed();
        drive_en = 1'b1;
        run_seq(2, 1, 1'b0);
        run_seq(0, 2, 1'b0);
    endtask

    task automatic test_perturb();
        run_seq(3, 1, 1'b1);
    endtask

    task automatic test_abort();
        bit found;
        @(negedge wb_clk_i);
        period = 16'd1;
        iterations = 4'd1;
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (gpio_out === 34'h100) found = 1'b1;
            else @(negedge wb_clk_i);
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL abort_wait got=%h want=100 within 100 cycles",
                     gpio_out);
        end
        abort = 1'b1;
        @(negedge wb_clk_i);
        abort = 1'b0;
        tests++;
        if (gpio_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort out=%h busy=%b done=%b want 0 0 0",
                     gpio_out, busy, done);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_quiet cyc=%0d done=%b busy=%b want 0 0",
                         i, done, busy);
            end
        end
        run_seq(1, 1, 1'b0);
    endtask

    task automatic test_zero_iter();
        @(negedge wb_clk_i);
        period = 16'd2;
        iterations = 4'd0;
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || gpio_out !== '0) begin
            fails++;
            $display("FAIL zero_iter done=%b busy=%b out=%h want 1 0 0",
                     done, busy, gpio_out);
        end
        @(negedge wb_clk_i);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_iter_after done=%b busy=%b want 0 0",
                     done, busy);
        end
        iterations = 4'd2;
        period = 16'd1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (busy !== 1'b0 || done !== 1'b0 || gpio_out !== '0) begin
                fails++;
                $display("FAIL abort_start cyc=%0d busy=%b done=%b out=%h want 0 0 0",
                         i, busy, done, gpio_out);
            end
            @(negedge wb_clk_i);
        end
    endtask

    task automatic test_reset_mid();
        drive_en = 1'b1;
        @(negedge wb_clk_i);
        period = 16'd1;
        iterations = 4'd1;
        start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        repeat (15) @(negedge wb_clk_i);
        tests++;
        if (busy !== 1'b1 || gpio_out === '0) begin
            fails++;
            $display("FAIL pre_reset busy=%b out=%h want busy=1 out!=0",
                     busy, gpio_out);
        end
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        tests++;
        if (gpio_out !== '0 || gpio_oeb !== '1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid out=%h oeb=%h busy=%b done=%b want 0 all1 0 0",
                     gpio_out, gpio_oeb, busy, done);
        end
        run_seq(2, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            drive_en = 1'($urandom_range(0, 1));
            run_seq(int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        drive_en = 1'b1;
        run_seq(1, 1, 1'b0);
        run_seq(2, 2, 1'b0);
    endtask

    initial begin
        wb_rst_i   = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        period     = '0;
        iterations = '0;
        drive_en   = 1'b0;
        test_reset();
        test_directed();
        test_perturb();
        test_abort();
        test_zero_iter();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
